exe_hazard_ctrl: RTL and testbench

- Pipeline hazard controller that sequences the execute stage.
- Tracks the instruction entering EX and generates the operand forwarding selects for EX.
- Inserts load-use stall bubbles and flushes IF/ID after a taken branch or JALR resolved in EX.
- Sits beside the decode/execute boundary. Drives the EX enable, the IF/ID stall and flush lines, and the 2-bit forward selects.

---
 rtl/exe_hazard_ctrl_if.sv | 59 +++++
 rtl/exe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_exe_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_hazard_ctrl_if.sv
// Signal bundle for exe_hazard_ctrl. It carries the decode, MA and WB inputs and the EX control outputs.
// Defining HAZ_PERF_CNT_EN adds o_stall_cnt and o_flush_cnt.
interface exe_hazard_ctrl_if #(
  parameter int NUM_REGS   = 32,
  parameter int PERF_CNT_W = 32
);
  localparam int RW = $clog2(NUM_REGS);

  if (NUM_REGS < 2 || PERF_CNT_W < 1) begin : g_param_err
    $error("exe_hazard_ctrl_if: illegal parameter value");
  end

  logic [RW-1:0] i_id_rs1;
  logic [RW-1:0] i_id_rs2;
  logic          i_id_use_rs1;
  logic          i_id_use_rs2;
  logic [RW-1:0] i_id_rdest;
  logic          i_id_regwrite;
  logic          i_id_load;
  logic          i_ex_branch_valid;
  logic [RW-1:0] i_ma_rdest;
  logic          i_ma_regwrite;
  logic [RW-1:0] i_wb_rdest;
  logic          i_wb_regwrite;
  logic          o_ex_en;
  logic          o_pc_stall;
  logic          o_ifid_stall;
  logic          o_ifid_flush;
  logic [1:0]    o_forward_a;
  logic [1:0]    o_forward_b;
`ifdef HAZ_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] o_stall_cnt;
  logic [PERF_CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_rdest, i_id_regwrite,
           i_id_load, i_ex_branch_valid, i_ma_rdest, i_ma_regwrite, i_wb_rdest, i_wb_regwrite,
    input  o_ex_en, o_pc_stall, o_ifid_stall, o_ifid_flush, o_forward_a, o_forward_b,
           o_stall_cnt, o_flush_cnt
  );
  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_rdest, i_id_regwrite,
           i_id_load, i_ex_branch_valid, i_ma_rdest, i_ma_regwrite, i_wb_rdest, i_wb_regwrite,
    output o_ex_en, o_pc_stall, o_ifid_stall, o_ifid_flush, o_forward_a, o_forward_b,
           o_stall_cnt, o_flush_cnt
  );
`else
  modport master (
    output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_rdest, i_id_regwrite,
           i_id_load, i_ex_branch_valid, i_ma_rdest, i_ma_regwrite, i_wb_rdest, i_wb_regwrite,
    input  o_ex_en, o_pc_stall, o_ifid_stall, o_ifid_flush, o_forward_a, o_forward_b
  );
  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_id_rdest, i_id_regwrite,
           i_id_load, i_ex_branch_valid, i_ma_rdest, i_ma_regwrite, i_wb_rdest, i_wb_regwrite,
    output o_ex_en, o_pc_stall, o_ifid_stall, o_ifid_flush, o_forward_a, o_forward_b
  );
`endif
endinterface

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard controller. It produces operand forwarding, load-use stall bubbles and the IF/ID flush on a branch.
// Defining HAZ_PERF_CNT_EN adds stall and flush performance counters.
module exe_hazard_ctrl #(
  parameter int NUM_REGS       = 32,
  parameter int LOAD_USE_STALL = 1,
  parameter int PERF_CNT_W     = 32
) (
  input logic              i_aclk,
  input logic              i_areset,
  exe_hazard_ctrl_if.slave hz_bus
);
  localparam int RW = $clog2(NUM_REGS);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

  if (LOAD_USE_STALL < 1 || LOAD_USE_STALL > 3 || PERF_CNT_W < 1) begin : g_param_err
    $error("exe_hazard_ctrl: illegal parameter value");
  end

  logic [1:0]    state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic          ex_en, pc_stall, ifid_flush, hz;

  logic [RW-1:0] ex_rs1, ex_rs2, ex_rdest;
  logic          ex_use1, ex_use2, ex_regwrite, ex_load;

  function automatic logic [1:0] fwd_sel(
    input logic          use_rs,
    input logic [RW-1:0] rs,
    input logic          ma_we,
    input logic [RW-1:0] ma_rd,
    input logic          wb_we,
    input logic [RW-1:0] wb_rd
  );
    if (use_rs && rs != '0 && ma_we && ma_rd == rs) return 2'b01;
    if (use_rs && rs != '0 && wb_we && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  assign hz = ex_load & ex_regwrite & (ex_rdest != '0) &
              ((hz_bus.i_id_use_rs1 & (hz_bus.i_id_rs1 == ex_rdest)) |
               (hz_bus.i_id_use_rs2 & (hz_bus.i_id_rs2 == ex_rdest)));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ex_en      = 1'b1;
    pc_stall   = 1'b0;
    ifid_flush = 1'b0;
    case (state)
      ST_RUN: begin
        if (hz_bus.i_ex_branch_valid) begin
          ifid_flush = 1'b1;
          ex_en      = 1'b0;
          state_nxt  = ST_FLUSH;
        end else if (hz) begin
          pc_stall = 1'b1;
          ex_en    = 1'b0;
          cnt_nxt  = STALL_INIT;
          if (STALL_INIT != 2'd0) state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        pc_stall = 1'b1;
        ex_en    = 1'b0;
        // The first stall cycle is spent in RUN, so STALL covers the remaining LOAD_USE_STALL-1.
        if (cnt <= 2'd1) begin
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rdest    <= '0;
      ex_use1     <= 1'b0;
      ex_use2     <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_load     <= 1'b0;
    end else if (ex_en) begin
      ex_rs1      <= hz_bus.i_id_rs1;
      ex_rs2      <= hz_bus.i_id_rs2;
      ex_rdest    <= hz_bus.i_id_rdest;
      ex_use1     <= hz_bus.i_id_use_rs1;
      ex_use2     <= hz_bus.i_id_use_rs2;
      ex_regwrite <= hz_bus.i_id_regwrite;
      ex_load     <= hz_bus.i_id_load;
    end else begin
      ex_use1     <= 1'b0;
      ex_use2     <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_load     <= 1'b0;
    end
  end

  // Reset gates the outputs combinationally, so an in-flight stall or flush disappears at once.
  assign hz_bus.o_ex_en      = ex_en & ~i_areset;
  assign hz_bus.o_pc_stall   = pc_stall & ~i_areset;
  assign hz_bus.o_ifid_stall = pc_stall & ~i_areset;
  assign hz_bus.o_ifid_flush = ifid_flush & ~i_areset;
  assign hz_bus.o_forward_a  = fwd_sel(ex_use1, ex_rs1, hz_bus.i_ma_regwrite, hz_bus.i_ma_rdest,
                                       hz_bus.i_wb_regwrite, hz_bus.i_wb_rdest);
  assign hz_bus.o_forward_b  = fwd_sel(ex_use2, ex_rs2, hz_bus.i_ma_regwrite, hz_bus.i_ma_rdest,
                                       hz_bus.i_wb_regwrite, hz_bus.i_wb_rdest);

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall)   stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz_bus.o_stall_cnt = stall_cnt;
  assign hz_bus.o_flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Testbench for exe_hazard_ctrl. Two instances (LOAD_USE_STALL=1 and LOAD_USE_STALL=3) receive identical stimulus.
// Each cycle a reference model pushes the expected outputs into a queue, and a monitor pops and compares them.
module tb_exe_hazard_ctrl;
  localparam int NR = 32;
  localparam int RW = 5;
  localparam int PW = 32;

  typedef struct packed {
    logic [RW-1:0] rs1, rs2, rdest, ma_rd, wb_rd;
    logic use1, use2, regwrite, load, branch, ma_we, wb_we;
  } stim_t;

  typedef struct packed {
    logic use1, use2, regwrite, load;
    logic [RW-1:0] rs1, rs2, rdest;
  } ex_t;

  typedef struct {
    logic ex_en, pc_stall, ifid_stall, flush;
    logic [1:0] fa, fb;
    logic [PW-1:0] scnt, fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_hazard_ctrl_if #(.NUM_REGS(NR), .PERF_CNT_W(PW)) bus0 ();
  exe_hazard_ctrl_if #(.NUM_REGS(NR), .PERF_CNT_W(PW)) bus1 ();

  exe_hazard_ctrl #(.NUM_REGS(NR), .LOAD_USE_STALL(1), .PERF_CNT_W(PW)) u_dut0 (
    .i_aclk(clk), .i_areset(rst), .hz_bus(bus0));
  exe_hazard_ctrl #(.NUM_REGS(NR), .LOAD_USE_STALL(3), .PERF_CNT_W(PW)) u_dut1 (
    .i_aclk(clk), .i_areset(rst), .hz_bus(bus1));

  int total = 0;
  int bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  ex_t           mex[2];
  int            stall_left[2];
  bit            flush_pend[2];
  logic [PW-1:0] mscnt[2];
  logic [PW-1:0] mfcnt[2];
  int            lus[2] = '{1, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic u, input logic [RW-1:0] rs, input stim_t s);
    if (!u || rs == 0) return 2'd0;
    if (s.ma_we && s.ma_rd == rs) return 2'd1;
    if (s.wb_we && s.wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  // Expected outputs for the current cycle; advances the model to the state after the next edge.
  function automatic exp_t model_step(input int k, input stim_t s, input logic r);
    exp_t e;
    bit hzd;
    e = '{default: '0};
    if (r) begin
      mex[k] = '0; stall_left[k] = 0; flush_pend[k] = 0; mscnt[k] = '0; mfcnt[k] = '0;
      return e;
    end
    e.scnt = mscnt[k];
    e.fcnt = mfcnt[k];
    e.fa = ref_fwd(mex[k].use1, mex[k].rs1, s);
    e.fb = ref_fwd(mex[k].use2, mex[k].rs2, s);
    hzd = mex[k].load && mex[k].regwrite && mex[k].rdest != 0 &&
          ((s.use1 && s.rs1 == mex[k].rdest) || (s.use2 && s.rs2 == mex[k].rdest));
    if (flush_pend[k]) begin
      flush_pend[k] = 0; e.ex_en = 1;
    end else if (stall_left[k] > 0) begin
      stall_left[k]--; e.pc_stall = 1; e.ifid_stall = 1;
    end else if (s.branch) begin
      e.flush = 1; flush_pend[k] = 1;
    end else if (hzd) begin
      e.pc_stall = 1; e.ifid_stall = 1; stall_left[k] = lus[k] - 1;
    end else begin
      e.ex_en = 1;
    end
    if (e.pc_stall) mscnt[k] = mscnt[k] + 1;
    if (e.flush) mfcnt[k] = mfcnt[k] + 1;
    if (e.ex_en) mex[k] = '{use1: s.use1, use2: s.use2, regwrite: s.regwrite, load: s.load,
                            rs1: s.rs1, rs2: s.rs2, rdest: s.rdest};
    else mex[k] = '0;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus0.i_id_rs1 = s.rs1;       bus1.i_id_rs1 = s.rs1;
    bus0.i_id_rs2 = s.rs2;       bus1.i_id_rs2 = s.rs2;
    bus0.i_id_use_rs1 = s.use1;  bus1.i_id_use_rs1 = s.use1;
    bus0.i_id_use_rs2 = s.use2;  bus1.i_id_use_rs2 = s.use2;
    bus0.i_id_rdest = s.rdest;   bus1.i_id_rdest = s.rdest;
    bus0.i_id_regwrite = s.regwrite; bus1.i_id_regwrite = s.regwrite;
    bus0.i_id_load = s.load;     bus1.i_id_load = s.load;
    bus0.i_ex_branch_valid = s.branch; bus1.i_ex_branch_valid = s.branch;
    bus0.i_ma_rdest = s.ma_rd;   bus1.i_ma_rdest = s.ma_rd;
    bus0.i_ma_regwrite = s.ma_we; bus1.i_ma_regwrite = s.ma_we;
    bus0.i_wb_rdest = s.wb_rd;   bus1.i_wb_rdest = s.wb_rd;
    bus0.i_wb_regwrite = s.wb_we; bus1.i_wb_regwrite = s.wb_we;
  endtask

  task automatic cycle(input stim_t s, input logic r);
    @(posedge clk);
    #1;
    rst = r;
    drive(s);
    q0.push_back(model_step(0, s, r));
    q1.push_back(model_step(1, s, r));
  endtask

  task automatic chk_ctl(input string n, input int k, input logic en, input logic stl, input logic fl);
    if (k == 0) begin
      check({n, "_ex_en0"}, 32'(bus0.o_ex_en), 32'(en));
      check({n, "_pc_stall0"}, 32'(bus0.o_pc_stall), 32'(stl));
      check({n, "_ifid_stall0"}, 32'(bus0.o_ifid_stall), 32'(stl));
      check({n, "_flush0"}, 32'(bus0.o_ifid_flush), 32'(fl));
    end else begin
      check({n, "_ex_en1"}, 32'(bus1.o_ex_en), 32'(en));
      check({n, "_pc_stall1"}, 32'(bus1.o_pc_stall), 32'(stl));
      check({n, "_ifid_stall1"}, 32'(bus1.o_ifid_stall), 32'(stl));
      check({n, "_flush1"}, 32'(bus1.o_ifid_flush), 32'(fl));
    end
  endtask

  task automatic cmp(input string n, input exp_t e, input logic en, input logic pcs, input logic ifs,
                     input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [PW-1:0] sc, input logic [PW-1:0] fc);
    check({n, "_ex_en"}, 32'(en), 32'(e.ex_en));
    check({n, "_pc_stall"}, 32'(pcs), 32'(e.pc_stall));
    check({n, "_ifid_stall"}, 32'(ifs), 32'(e.ifid_stall));
    check({n, "_ifid_flush"}, 32'(fl), 32'(e.flush));
    check({n, "_forward_a"}, 32'(fa), 32'(e.fa));
    check({n, "_forward_b"}, 32'(fb), 32'(e.fb));
`ifdef HAZ_PERF_CNT_EN
    check({n, "_stall_cnt"}, 32'(sc), 32'(e.scnt));
    check({n, "_flush_cnt"}, 32'(fc), 32'(e.fcnt));
`else
    if (sc !== fc) begin end
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [PW-1:0] sc0, fc0, sc1, fc1;
`ifdef HAZ_PERF_CNT_EN
    sc0 = bus0.o_stall_cnt; fc0 = bus0.o_flush_cnt;
    sc1 = bus1.o_stall_cnt; fc1 = bus1.o_flush_cnt;
`else
    sc0 = '0; fc0 = '0; sc1 = '0; fc1 = '0;
`endif
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("sb0", e, bus0.o_ex_en, bus0.o_pc_stall, bus0.o_ifid_stall, bus0.o_ifid_flush,
          bus0.o_forward_a, bus0.o_forward_b, sc0, fc0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("sb1", e, bus1.o_ex_en, bus1.o_pc_stall, bus1.o_ifid_stall, bus1.o_ifid_flush,
          bus1.o_forward_a, bus1.o_forward_b, sc1, fc1);
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1 = RW'($urandom_range(0, 7));
    s.rs2 = RW'($urandom_range(0, 7));
    s.rdest = RW'($urandom_range(0, 7));
    s.ma_rd = RW'($urandom_range(0, 7));
    s.wb_rd = RW'($urandom_range(0, 7));
    s.use1 = 1'($urandom_range(0, 1));
    s.use2 = 1'($urandom_range(0, 1));
    s.regwrite = 1'($urandom_range(0, 3) != 0);
    s.load = 1'($urandom_range(0, 2) == 0);
    s.branch = 1'($urandom_range(0, 7) == 0);
    s.ma_we = 1'($urandom_range(0, 1));
    s.wb_we = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    stim_t s0, s;
    s0 = '0;
    rst = 1'b1;
    drive(s0);

    // Reset: every output low.
    cycle(s0, 1'b1);
    cycle(s0, 1'b1);
    @(negedge clk);
    chk_ctl("reset", 0, 1'b0, 1'b0, 1'b0);
    chk_ctl("reset", 1, 1'b0, 1'b0, 1'b0);
    check("reset_fa0", 32'(bus0.o_forward_a), 32'd0);
    cycle(s0, 1'b0);
    @(negedge clk);
    chk_ctl("release", 0, 1'b1, 1'b0, 1'b0);

    // MA has priority over WB; x0 is never forwarded.
    s = s0; s.rs1 = 5'd5; s.use1 = 1'b1;
    cycle(s, 1'b0);
    s = s0; s.ma_rd = 5'd5; s.ma_we = 1'b1; s.wb_rd = 5'd5; s.wb_we = 1'b1;
    cycle(s, 1'b0);
    @(negedge clk);
    check("fwd_ma_a0", 32'(bus0.o_forward_a), 32'd1);
    check("fwd_ma_a1", 32'(bus1.o_forward_a), 32'd1);
    s = s0; s.use1 = 1'b1;
    cycle(s, 1'b0);
    s = s0; s.ma_we = 1'b1; s.wb_we = 1'b1;
    cycle(s, 1'b0);
    @(negedge clk);
    check("fwd_x0_a0", 32'(bus0.o_forward_a), 32'd0);

    // Load-use hazard: a load with rdest=7 in EX and a consumer reading rs2=7 in ID.
    s = s0; s.rdest = 5'd7; s.regwrite = 1'b1; s.load = 1'b1;
    cycle(s, 1'b0);
    s = s0; s.rs2 = 5'd7; s.use2 = 1'b1;
    cycle(s, 1'b0);
    @(negedge clk);
    chk_ctl("lu_stall", 0, 1'b0, 1'b1, 1'b0);
    chk_ctl("lu_stall", 1, 1'b0, 1'b1, 1'b0);
    cycle(s, 1'b0);
    @(negedge clk);
    chk_ctl("lu_done", 0, 1'b1, 1'b0, 1'b0);
    chk_ctl("lu_hold", 1, 1'b0, 1'b1, 1'b0);
    s.wb_rd = 5'd7; s.wb_we = 1'b1;
    cycle(s, 1'b0);
    @(negedge clk);
    check("lu_fwd_wb_b0", 32'(bus0.o_forward_b), 32'd2);
    chk_ctl("lu_hold3", 1, 1'b0, 1'b1, 1'b0);
    cycle(s0, 1'b0);
    @(negedge clk);
    chk_ctl("lu3_done", 1, 1'b1, 1'b0, 1'b0);

    // Reset asserted while the LOAD_USE_STALL=3 instance is stalling.
    s = s0; s.rdest = 5'd7; s.regwrite = 1'b1; s.load = 1'b1;
    cycle(s, 1'b0);
    s = s0; s.rs2 = 5'd7; s.use2 = 1'b1;
    cycle(s, 1'b0);
    cycle(s, 1'b1);
    @(negedge clk);
    chk_ctl("rst_mid", 1, 1'b0, 1'b0, 1'b0);
    chk_ctl("rst_mid", 0, 1'b0, 1'b0, 1'b0);
    cycle(s0, 1'b0);
    @(negedge clk);
    chk_ctl("rst_rel", 1, 1'b1, 1'b0, 1'b0);

    // Taken branch: one flush cycle, then EX runs again with no forwarding.
    s = s0; s.branch = 1'b1;
    cycle(s, 1'b0);
    @(negedge clk);
    chk_ctl("br", 0, 1'b0, 1'b0, 1'b1);
    chk_ctl("br", 1, 1'b0, 1'b0, 1'b1);
    cycle(s0, 1'b0);
    @(negedge clk);
    chk_ctl("br_after", 0, 1'b1, 1'b0, 1'b0);
    check("br_after_fa", 32'(bus0.o_forward_a), 32'd0);
    check("br_after_fb", 32'(bus0.o_forward_b), 32'd0);

    // A branch and a load-use hazard in the same cycle: only the flush is taken.
    cycle(s0, 1'b1);
    cycle(s0, 1'b0);
    s = s0; s.rdest = 5'd7; s.regwrite = 1'b1; s.load = 1'b1;
    cycle(s, 1'b0);
    s = s0; s.rs1 = 5'd7; s.use1 = 1'b1; s.branch = 1'b1;
    cycle(s, 1'b0);
    @(negedge clk);
    chk_ctl("br_hz", 0, 1'b0, 1'b0, 1'b1);
    chk_ctl("br_hz", 1, 1'b0, 1'b0, 1'b1);
    cycle(s0, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    check("br_hz_flush_cnt", 32'(bus0.o_flush_cnt), 32'd1);
    check("br_hz_stall_cnt", 32'(bus0.o_stall_cnt), 32'd0);
`endif

    // Randomised traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(rand_stim(), 1'($urandom_range(0, 99) == 0));
    end
    cycle(s0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
